// File: rtl/test_ram_arb.sv
// rtl/test_ram_arb.sv - multi-channel test RAM with round-robin arbitration and wait states
module test_ram_arb #(
  parameter int                    ADDR_WIDTH  = 16,
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    DEPTH       = 65536,
  parameter int                    WAIT_STATES = 2,
  parameter int                    NUM_CH      = 2,
  parameter logic [DATA_WIDTH-1:0] OOR_DATA    = '1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            req,
  input  logic [NUM_CH-1:0]            we,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] addr,
  input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
  output logic [NUM_CH*DATA_WIDTH-1:0] data_out,
  output logic [NUM_CH-1:0]            data_ready,
  output logic                         busy,
  output logic [1:0]                   grant
);

  localparam int MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t                  state, state_nxt;
  logic [1:0]              ptr;
  logic [3:0]              cnt;
  logic                    lat_we;
  logic [ADDR_WIDTH-1:0]   lat_addr;
  logic [DATA_WIDTH-1:0]   lat_data;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    win_valid;
  logic [1:0]              win;
  logic [3:0]              req_pad;
  logic [1:0]              idx;
  logic [3:0]              dr_pad;
  logic                    in_range;
  logic                    access;
  logic                    mem_we;
  logic [MW-1:0]           mem_idx;

  assign in_range = ({1'b0, lat_addr} < (ADDR_WIDTH+1)'(DEPTH));
  assign mem_idx  = lat_addr[MW-1:0];
  assign access   = (state == S_WAIT) && (cnt == 4'd0);
  assign mem_we   = access && lat_we && in_range;

  // Search upward from the channel after the last winner so every requester is served in rotation.
  always_comb begin
    win_valid = 1'b0;
    win       = ptr;
    idx       = 2'd0;
    req_pad   = 4'(req);
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = 2'((int'(ptr) + k) % NUM_CH);
      if (!win_valid && req_pad[idx]) begin
        win_valid = 1'b1;
        win       = idx;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (win_valid) state_nxt = S_WAIT;
      S_WAIT: if (cnt == 4'd0) state_nxt = S_ACK;
      S_ACK:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    dr_pad     = 4'b0001 << grant;
    data_ready = (state == S_ACK) ? dr_pad[NUM_CH-1:0] : '0;
    busy       = (state != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      ptr      <= 2'(NUM_CH - 1);
      grant    <= 2'd0;
      cnt      <= 4'd0;
      lat_we   <= 1'b0;
      lat_addr <= '0;
      lat_data <= '0;
      data_out <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && win_valid) begin
        grant    <= win;
        ptr      <= win;
        cnt      <= 4'(WAIT_STATES);
        lat_we   <= we[win];
        lat_addr <= addr[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
        lat_data <= data_in[int'(win)*DATA_WIDTH +: DATA_WIDTH];
      end
      if (state == S_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (access && !lat_we) begin
        data_out[int'(grant)*DATA_WIDTH +: DATA_WIDTH] <= in_range ? mem[mem_idx] : OOR_DATA;
      end
    end
  end

  // Memory is deliberately left out of reset so bench contents survive a core reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_idx] <= lat_data;
  end

endmodule

// File: tb/tb_test_ram_arb.sv
// tb/tb_test_ram_arb.sv - self-checking bench for test_ram_arb
module tb_test_ram_arb;

  localparam int WS0    = 2;
  localparam int DEPTH0 = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic [1:0]  r0 = '0, w0 = '0, dr0;
  logic [31:0] a0 = '0;
  logic [15:0] d0 = '0, q0;
  logic        b0;
  logic [1:0]  g0;

  logic [1:0]  r1 = '0, w1 = '0, dr1;
  logic [31:0] a1 = '0;
  logic [15:0] d1 = '0, q1;
  logic        b1;
  logic [1:0]  g1;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem_m [DEPTH0];
  logic [7:0] dout_m [2];
  int         ptr_m;

  always #5 clk = ~clk;

  test_ram_arb #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .DEPTH(DEPTH0), .WAIT_STATES(WS0), .NUM_CH(2)) u0 (
    .clk(clk), .rst(rst), .req(r0), .we(w0), .addr(a0), .data_in(d0),
    .data_out(q0), .data_ready(dr0), .busy(b0), .grant(g0)
  );

  test_ram_arb #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .DEPTH(DEPTH0), .WAIT_STATES(0), .NUM_CH(2)) u1 (
    .clk(clk), .rst(rst), .req(r1), .we(w1), .addr(a1), .data_in(d1),
    .data_out(q1), .data_ready(dr1), .busy(b1), .grant(g1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    chk("rst_busy0", b0, 0);
    chk("rst_ready0", dr0, 0);
    chk("rst_dout0", q0, 0);
    chk("rst_grant0", g0, 0);
    chk("rst_busy1", b1, 0);
    chk("rst_dout1", q1, 0);
    rst = 1'b1;
    dout_m[0] = 8'h00;
    dout_m[1] = 8'h00;
    ptr_m = 1;
  endtask

  // One isolated transaction on u0 from an idle DUT, checked against the model.
  task automatic txn0(input int ch, input bit wr, input logic [15:0] ad, input logic [7:0] dt);
    int  lat;
    bit  seen;
    lat  = 0;
    seen = 1'b0;
    w0[ch] = wr;
    a0[ch*16 +: 16] = ad;
    d0[ch*8 +: 8] = dt;
    r0[ch] = 1'b1;
    while (!seen && lat < 50) begin
      tick();
      lat++;
      if (dr0[ch]) seen = 1'b1;
    end
    r0[ch] = 1'b0;
    chk("txn_seen", seen, 1);
    chk("txn_latency", lat, WS0 + 2);
    chk("txn_grant", g0, ch);
    ptr_m = ch;
    if (wr) begin
      if (ad < 16'(DEPTH0)) mem_m[ad[7:0]] = dt;
    end else begin
      dout_m[ch] = (ad >= 16'(DEPTH0)) ? 8'hFF : mem_m[ad[7:0]];
    end
    chk("txn_dout_ch0", q0[7:0], dout_m[0]);
    chk("txn_dout_ch1", q0[15:8], dout_m[1]);
    tick();
    chk("txn_ready_width", dr0, 0);
    chk("txn_busy_after", b0, 0);
  endtask

  // Held reads on the channels in mask; expected winner follows round-robin from the last grant.
  task automatic held(input logic [1:0] mask, input logic [15:0] ad_a, input logic [15:0] ad_b, input int n);
    int got  = 0;
    int t    = 0;
    int last = -1;
    int idle = 0;
    int exp_ch;
    w0 = 2'b00;
    a0 = {ad_b, ad_a};
    r0 = mask;
    while (got < n && t < 200) begin
      tick();
      t++;
      if (!b0) idle++;
      if (dr0 != 2'b00) begin
        exp_ch = -1;
        for (int k = 1; k <= 2; k++) begin
          if (exp_ch < 0 && mask[(ptr_m + k) % 2]) exp_ch = (ptr_m + k) % 2;
        end
        ptr_m = exp_ch;
        dout_m[exp_ch] = mem_m[(exp_ch == 1) ? ad_b[7:0] : ad_a[7:0]];
        chk("rr_ready", dr0, 2'b01 << exp_ch);
        chk("rr_grant", g0, exp_ch);
        chk("rr_dout_ch0", q0[7:0], dout_m[0]);
        chk("rr_dout_ch1", q0[15:8], dout_m[1]);
        if (last >= 0) begin
          chk("rr_spacing", t - last, WS0 + 3);
          chk("rr_idle_gap", idle, 1);
        end
        last = t;
        idle = 0;
        got++;
      end
    end
    r0 = 2'b00;
    chk("rr_count", got, n);
    tick();
    chk("rr_busy_end", b0, 0);
  endtask

  initial begin
    int kind;
    int ch;
    logic [15:0] ad;

    do_reset();

    // Single write then read-back on ch0.
    txn0(0, 1'b1, 16'h0010, 8'h5A);
    txn0(0, 1'b0, 16'h0010, 8'h00);
    chk("single_read", q0[7:0], 8'h5A);
    chk("single_other_ch", q0[15:8], 8'h00);

    for (int a = 0; a < 48; a++) begin
      txn0(a % 2, 1'b1, 16'(a), 8'($urandom));
    end

    // Random mix of in-range and out-of-range reads and writes.
    for (int i = 0; i < 24; i++) begin
      kind = int'($urandom_range(0, 3));
      ch   = int'($urandom_range(0, 1));
      ad   = (kind < 2) ? 16'($urandom_range(0, 47)) : 16'(DEPTH0 + int'($urandom_range(0, 1000)));
      txn0(ch, (kind == 0) || (kind == 3), ad, 8'($urandom));
    end

    // Out-of-range write is discarded, read returns all ones.
    txn0(1, 1'b1, 16'h0100, 8'hAA);
    txn0(1, 1'b0, 16'h0100, 8'h00);
    chk("oor_read", q0[15:8], 8'hFF);
    txn0(1, 1'b0, 16'h0000, 8'h00);

    // Reset in the middle of a write: nothing is committed.
    w0[0] = 1'b1;
    a0[15:0] = 16'h0020;
    d0[7:0] = 8'h33;
    r0[0] = 1'b1;
    tick();
    tick();
    chk("midrst_busy_pre", b0, 1);
    rst = 1'b0;
    #1;
    chk("midrst_busy", b0, 0);
    chk("midrst_ready", dr0, 0);
    r0 = 2'b00;
    tick();
    chk("midrst_ready_later", dr0, 0);
    do_reset();
    txn0(0, 1'b0, 16'h0020, 8'h00);

    // Contention right after reset, then a single channel holding req.
    do_reset();
    held(2'b11, 16'h0003, 16'h0004, 4);
    held(2'b10, 16'h0005, 16'h0006, 2);

    // Zero wait states on u1.
    for (int j = 0; j < 2; j++) begin
      w1 = 2'b01;
      a1[15:0] = (j == 0) ? 16'h0005 : 16'h0006;
      d1[7:0]  = (j == 0) ? 8'h77 : 8'h11;
      r1 = 2'b01;
      tick();
      chk("ws0_wr_accept_busy", b1, 1);
      tick();
      chk("ws0_wr_ready", dr1, 2'b01);
      r1 = 2'b00;
      tick();
      chk("ws0_wr_ready_drop", dr1, 0);
    end
    w1 = 2'b00;
    a1[15:0] = 16'h0005;
    r1 = 2'b01;
    tick();
    a1[15:0] = 16'h0006;
    tick();
    chk("ws0_rd_ready", dr1, 2'b01);
    chk("ws0_rd_latched_addr", q1[7:0], 8'h77);
    chk("ws0_rd_other_ch", q1[15:8], 8'h00);
    r1 = 2'b00;
    tick();
    a1[31:16] = 16'h0006;
    r1 = 2'b10;
    tick();
    tick();
    chk("ws0_ch1_ready", dr1, 2'b10);
    chk("ws0_ch1_data", q1[15:8], 8'h11);
    chk("ws0_ch0_kept", q1[7:0], 8'h77);
    chk("ws0_grant", g1, 1);
    r1 = 2'b00;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/test_ram_arb.md
Name: test_ram_arb

Overview:
- Parametrised successor to the single-port test RAM used by simulation benches for the 65c816 core.
- Provides NUM_CH independent requester channels sharing one memory array through a round-robin arbiter.
- Inserts a programmable number of wait states per access and pulses a per-channel data_ready on completion.
- Lets benches model slow memory and multi-master contention (CPU plus DMA/bench stimulus).

Parameters:
- ADDR_WIDTH, 16, address bits per channel.
- DATA_WIDTH, 8, data bits.
- DEPTH, 65536, implemented words; must be <= 2**ADDR_WIDTH.
- WAIT_STATES, 2, extra clocks per access, 0..15.
- NUM_CH, 2, requester channels, 1..4.
- OOR_DATA, all ones, read value returned for addresses >= DEPTH.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  NUM_CH  per-channel request level.
- we  in  NUM_CH  per-channel write enable; 1 = write, 0 = read.
- addr  in  NUM_CH*ADDR_WIDTH  flattened addresses; channel i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- data_in  in  NUM_CH*DATA_WIDTH  flattened write data.
- data_out  out  NUM_CH*DATA_WIDTH  flattened per-channel read data, registered.
- data_ready  out  NUM_CH  one-cycle completion pulse per channel.
- busy  out  1  high while a transaction is in WAIT or ACK.
- grant  out  2  index of the channel owning the current or last transaction.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE; data_ready = 0; busy = 0; data_out = 0.
  - grant = 0; last-grant pointer = NUM_CH-1; wait counter = 0.
  - Memory contents are not cleared.
- FSM states: IDLE, WAIT, ACK.
- IDLE:
  - If any req bit is high at a rising edge, arbitrate.
  - Winner is the first requesting channel searching upward (modulo NUM_CH) from last-grant+1.
  - At that edge: latch the winner's we, addr and data_in; grant = winner; pointer = winner; counter = WAIT_STATES; go to WAIT.
  - No req high: stay in IDLE.
- WAIT:
  - If counter != 0: decrement and stay in WAIT.
  - If counter == 0, at that edge: perform the access using latched values.
    - Write: mem[addr] = data, only if addr < DEPTH.
    - Read: data_out[grant] = mem[addr], or OOR_DATA if addr >= DEPTH.
  - Then go to ACK.
- ACK:
  - data_ready[grant] = 1 for exactly this cycle; all other data_ready bits are 0.
  - req is ignored in ACK.
  - Next edge returns to IDLE.
- Latency: acceptance edge to data_ready high = WAIT_STATES+1 edges.
  - Full transaction = WAIT_STATES+3 cycles including the IDLE arbitration cycle.
  - Back-to-back requests from the same channel are spaced WAIT_STATES+3 cycles apart.
- busy = 1 in WAIT and ACK, 0 in IDLE.
- Requester protocol:
  - Hold req until data_ready is seen, then drop req.
  - If req is still high in the IDLE cycle after ACK, a new transaction is started (level-sensitive).
- Input changes on addr, we or data_in after acceptance have no effect on the in-flight access.
- data_out for a channel changes only on that channel's completed reads; writes and other channels' accesses leave it unchanged.
- Simultaneous requests: exactly one is granted per IDLE cycle. Losers keep req high and are served in rotation; with continuous contention, no channel waits more than NUM_CH transactions.
- Reset mid-transaction (WAIT or ACK): an uncommitted write is dropped; data_ready drops immediately; state = IDLE.
- Addresses >= DEPTH:
  - Writes are silently discarded.
  - Reads return OOR_DATA.
  - data_ready still pulses normally.
- WAIT_STATES = 0: the access occurs at the first WAIT edge; data_ready is high one cycle after acceptance.
- A grant index >= NUM_CH never occurs.

Test Plan:
- Reset then single write: ch0 writes 0x5A to 0x0010 with WAIT_STATES=2 -> data_ready[0] high exactly 3 edges after acceptance for 1 cycle. Ch0 read of 0x0010 then returns data_out[0]=0x5A; data_out[1] stays 0.
- Contention: ch0 and ch1 req the same cycle after reset -> ch0 granted first, ch1 next. Repeat with both held high -> grant order 0,1,0,1; busy drops only in the single IDLE gap cycles.
- Out-of-range: DEPTH=256, write 0xAA to 0x0100, then read 0x0100 -> read returns 0xFF, data_ready pulses. Read of 0x0000 is unchanged from its prior value.
- Zero wait states: WAIT_STATES=0, read -> data_ready one edge after acceptance. Addr changed to a different value the cycle after acceptance -> original address data is returned.
- Reset mid-write: assert rst low during WAIT of a write of 0x33 to 0x0020 -> data_ready never pulses, busy=0 immediately. A subsequent read of 0x0020 returns the old value.
- Held req: ch1 keeps req high through ACK -> second transaction accepted in the following IDLE cycle, data_ready pulses spaced WAIT_STATES+3 cycles apart.
